// File: rtl/picobello_pkg.sv
// Shared constants and types for the picobello dummy error tile.
package picobello_pkg;

  // Every transaction that reaches the dummy tile is answered with a decode error.
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read channel sequencing.
  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 interface (non-fall-through).
// DEPTH must be a power of two so the pointers wrap naturally.
// flush_i empties the FIFO synchronously; rst_ni is the asynchronous reset.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AddrDepth-1:0]  rd_ptr_q, wr_ptr_q;
  logic [AddrDepth:0]    cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push_ok, pop_ok;

  assign full_o  = (cnt_q == (AddrDepth+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AddrDepth'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrDepth'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AddrDepth+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AddrDepth+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pb_dummy_tile_err_slv.sv
// Dummy tile error slave: answers every AXI write and read with DECERR.
// Writes: AW IDs are queued, each W-last pops one ID into a single B slot.
// Reads: one burst at a time, len+1 zero-data beats with the latched ID.
// Optional macro PB_DUMMY_TILE_ERR_CNT_EN adds a saturating count of
// completed B responses and R bursts on err_cnt_o.
//
// state   | meaning
// R_IDLE  | ready to accept an AR
// R_BURST | emitting beats, counter = beats remaining minus one
module pb_dummy_tile_err_slv
  import picobello_pkg::*;
#(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxWrTxns = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o
`ifdef PB_DUMMY_TILE_ERR_CNT_EN
  ,
  output logic [31:0]          err_cnt_o
`endif
);

  // ---------------- write path ----------------
  logic               fifo_full, fifo_empty;
  logic [IdWidth-1:0] fifo_head;
  logic               aw_push, w_last_hs, b_hs;
  logic               b_valid_q;
  logic [IdWidth-1:0] b_id_q;

  assign aw_ready_o = ~fifo_full;
  assign aw_push    = aw_valid_i & aw_ready_o;
  // Only one B can be outstanding, so W is held off while it waits.
  assign w_ready_o  = ~fifo_empty & ~b_valid_q;
  assign w_last_hs  = w_valid_i & w_ready_o & w_last_i;
  assign b_hs       = b_valid_q & b_ready_i;

  fifo_v3 #(
    .DATA_WIDTH (IdWidth),
    .DEPTH      (MaxWrTxns)
  ) i_wr_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (1'b1),
    .flush_i (rst_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (aw_id_i),
    .push_i  (aw_push),
    .data_o  (fifo_head),
    .pop_i   (w_last_hs)
  );

  // B register: loaded from the FIFO head on W-last, cleared on handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
    end else if (w_last_hs) begin
      b_valid_q <= 1'b1;
      b_id_q    <= fifo_head;
    end else if (b_hs) begin
      b_valid_q <= 1'b0;
    end
  end

  assign b_valid_o = b_valid_q;
  assign b_id_o    = b_id_q;
  assign b_resp_o  = RESP_DECERR;

  // ---------------- read path ----------------
  r_state_e           r_state_q, r_state_d;
  logic [7:0]         r_cnt_q, r_cnt_d;
  logic [IdWidth-1:0] r_id_q, r_id_d;

  // Read FSM state, beat counter and latched ID.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_id_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_id_q    <= r_id_d;
    end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_state_d  = r_state_q;
    r_cnt_d    = r_cnt_q;
    r_id_d     = r_id_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          r_id_d    = ar_id_i;
          r_cnt_d   = ar_len_i;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        r_valid_o = 1'b1;
        r_last_o  = (r_cnt_q == 8'd0);
        if (r_ready_i) begin
          if (r_cnt_q == 8'd0) r_state_d = R_IDLE;
          else                 r_cnt_d   = r_cnt_q - 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign r_id_o   = r_id_q;
  assign r_data_o = '0;
  assign r_resp_o = RESP_DECERR;

`ifdef PB_DUMMY_TILE_ERR_CNT_EN
  // ---------------- error counter ----------------
  logic        r_last_hs;
  logic [32:0] err_sum;
  logic [31:0] err_cnt_q;

  assign r_last_hs = r_valid_o & r_ready_i & r_last_o;
  assign err_sum   = {1'b0, err_cnt_q} + 33'(b_hs) + 33'(r_last_hs);

  // Saturating count of completed write responses and read bursts.
  always_ff @(posedge clk_i) begin
    if (rst_i)        err_cnt_q <= '0;
    else if (err_sum[32]) err_cnt_q <= '1;
    else              err_cnt_q <= err_sum[31:0];
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_pb_dummy_tile_err_slv.sv
// Bench for pb_dummy_tile_err_slv: directed scenarios with literal checks,
// then random traffic, all compared every cycle against a queue-based model.
module tb_pb_dummy_tile_err_slv;

  localparam int IdWidth   = 4;
  localparam int DataWidth = 64;
  localparam int MaxWrTxns = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 aw_valid_i, aw_ready_o;
  logic [IdWidth-1:0]   aw_id_i;
  logic                 w_valid_i, w_ready_o, w_last_i;
  logic                 b_valid_o, b_ready_i;
  logic [IdWidth-1:0]   b_id_o;
  logic [1:0]           b_resp_o;
  logic                 ar_valid_i, ar_ready_o;
  logic [IdWidth-1:0]   ar_id_i;
  logic [7:0]           ar_len_i;
  logic                 r_valid_o, r_ready_i;
  logic [IdWidth-1:0]   r_id_o;
  logic [DataWidth-1:0] r_data_o;
  logic [1:0]           r_resp_o;
  logic                 r_last_o;
`ifdef PB_DUMMY_TILE_ERR_CNT_EN
  logic [31:0]          err_cnt_o;
`endif

  pb_dummy_tile_err_slv #(
    .IdWidth   (IdWidth),
    .DataWidth (DataWidth),
    .MaxWrTxns (MaxWrTxns)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .aw_id_i    (aw_id_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .w_last_i   (w_last_i),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .b_id_o     (b_id_o),
    .b_resp_o   (b_resp_o),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_last_o   (r_last_o)
`ifdef PB_DUMMY_TILE_ERR_CNT_EN
    ,
    .err_cnt_o  (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [IdWidth-1:0] m_q[$];
  bit                 m_b_pend;
  logic [IdWidth-1:0] m_b_id;
  bit                 m_r_act;
  logic [IdWidth-1:0] m_r_id;
  int                 m_r_left;
  longint             m_err;

  always @(posedge clk_i) begin
    bit aw_rdy, w_rdy, b_hs, r_hs, r_last_hs;
    if (rst_i) begin
      m_q.delete();
      m_b_pend = 0; m_b_id = '0;
      m_r_act = 0; m_r_id = '0; m_r_left = 0;
      m_err = 0;
    end else begin
      aw_rdy    = m_q.size() < MaxWrTxns;
      w_rdy     = (m_q.size() > 0) && !m_b_pend;
      b_hs      = m_b_pend && b_ready_i;
      r_hs      = m_r_act && r_ready_i;
      r_last_hs = r_hs && (m_r_left == 1);
      if (b_hs) m_b_pend = 0;
      if (w_valid_i && w_rdy && w_last_i) begin
        m_b_pend = 1;
        m_b_id   = m_q.pop_front();
      end
      if (aw_valid_i && aw_rdy) m_q.push_back(aw_id_i);
      if (r_hs) begin
        m_r_left--;
        if (m_r_left == 0) m_r_act = 0;
      end else if (!m_r_act && ar_valid_i) begin
        m_r_act  = 1;
        m_r_id   = ar_id_i;
        m_r_left = int'(ar_len_i) + 1;
      end
      m_err = m_err + longint'(b_hs) + longint'(r_last_hs);
      if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (started) begin
      chk("aw_ready", 64'(aw_ready_o), 64'(m_q.size() < MaxWrTxns));
      chk("w_ready",  64'(w_ready_o),  64'((m_q.size() > 0) && !m_b_pend));
      chk("b_valid",  64'(b_valid_o),  64'(m_b_pend));
      chk("b_id",     64'(b_id_o),     64'(m_b_id));
      chk("b_resp",   64'(b_resp_o),   64'd3);
      chk("ar_ready", 64'(ar_ready_o), 64'(!m_r_act));
      chk("r_valid",  64'(r_valid_o),  64'(m_r_act));
      chk("r_id",     64'(r_id_o),     64'(m_r_id));
      chk("r_last",   64'(r_last_o),   64'(m_r_act && (m_r_left == 1)));
      chk("r_data",   64'(r_data_o),   64'd0);
      chk("r_resp",   64'(r_resp_o),   64'd3);
`ifdef PB_DUMMY_TILE_ERR_CNT_EN
      chk("err_cnt",  64'(err_cnt_o),  64'(m_err));
`endif
    end
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int beats;
    bit done;
    rst_i = 1; aw_valid_i = 0; aw_id_i = '0; w_valid_i = 0; w_last_i = 0;
    b_ready_i = 0; ar_valid_i = 0; ar_id_i = '0; ar_len_i = '0; r_ready_i = 0;
    @(posedge clk_i);
    started = 1'b1;
    @(posedge clk_i);
    step();
    chk("rst_aw_ready", 64'(aw_ready_o), 64'd1);
    chk("rst_w_ready",  64'(w_ready_o),  64'd0);
    chk("rst_b_valid",  64'(b_valid_o),  64'd0);
    chk("rst_b_id",     64'(b_id_o),     64'd0);
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("rst_r_valid",  64'(r_valid_o),  64'd0);
    chk("rst_r_id",     64'(r_id_o),     64'd0);
    chk("rst_r_last",   64'(r_last_o),   64'd0);
    rst_i = 0;

    // single write, id 3
    aw_valid_i = 1; aw_id_i = 4'd3;
    step();
    aw_valid_i = 0;
    chk("wr1_w_ready", 64'(w_ready_o), 64'd1);
    w_valid_i = 1; w_last_i = 1; b_ready_i = 1;
    step();
    w_valid_i = 0;
    chk("wr1_b_valid", 64'(b_valid_o), 64'd1);
    chk("wr1_b_id",    64'(b_id_o),    64'd3);
    chk("wr1_b_resp",  64'(b_resp_o),  64'd3);
    step();
    chk("wr1_b_clear", 64'(b_valid_o), 64'd0);
    b_ready_i = 0;

    // read burst id 5, len 7, no back-pressure
    ar_valid_i = 1; ar_id_i = 4'd5; ar_len_i = 8'd7; r_ready_i = 1;
    step();
    ar_valid_i = 0;
    for (int k = 1; k <= 8; k++) begin
      chk("rd8_valid", 64'(r_valid_o),  64'd1);
      chk("rd8_last",  64'(r_last_o),   64'(k == 8));
      chk("rd8_arrdy", 64'(ar_ready_o), 64'd0);
      chk("rd8_id",    64'(r_id_o),     64'd5);
      step();
    end
    chk("rd8_end_valid", 64'(r_valid_o),  64'd0);
    chk("rd8_end_arrdy", 64'(ar_ready_o), 64'd1);
    r_ready_i = 0;

    // fill the ID FIFO, then W-last alongside a fifth AW
    for (int i = 0; i < 4; i++) begin
      aw_valid_i = 1; aw_id_i = 4'(i);
      step();
    end
    aw_valid_i = 0;
    chk("full_aw_ready", 64'(aw_ready_o), 64'd0);
    chk("full_w_ready",  64'(w_ready_o),  64'd1);
    aw_valid_i = 1; aw_id_i = 4'd4; w_valid_i = 1; w_last_i = 1;
    step();
    w_valid_i = 0;
    chk("full_b_valid",  64'(b_valid_o),  64'd1);
    chk("full_b_id",     64'(b_id_o),     64'd0);
    chk("full_aw_free",  64'(aw_ready_o), 64'd1);
    step();
    aw_valid_i = 0;
    chk("full_again",    64'(aw_ready_o), 64'd0);
    b_ready_i = 1; w_valid_i = 1; w_last_i = 1;
    repeat (12) step();
    w_valid_i = 0; b_ready_i = 0;
    step();
    chk("drain_w_ready", 64'(w_ready_o), 64'd0);
    chk("drain_b_valid", 64'(b_valid_o), 64'd0);

    // len 3 burst under random back-pressure
    ar_valid_i = 1; ar_id_i = 4'd9; ar_len_i = 8'd3; r_ready_i = 0;
    beats = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      ar_valid_i = 0;
      r_ready_i = (i > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      if (r_valid_o && r_ready_i) begin
        beats++;
        if (r_last_o) done = 1;
      end
    end
    chk("stall_done",  64'(done),  64'd1);
    chk("stall_beats", 64'(beats), 64'd4);
    step();
    r_ready_i = 0;
    chk("stall_end", 64'(r_valid_o), 64'd0);

    // reset during beat 2 of a len 5 burst, with a queued write ID
    aw_valid_i = 1; aw_id_i = 4'd7;
    step();
    aw_valid_i = 0;
    ar_valid_i = 1; ar_id_i = 4'd6; ar_len_i = 8'd5; r_ready_i = 1;
    step();
    ar_valid_i = 0;
    chk("mid_beat1", 64'(r_valid_o), 64'd1);
    step();
    rst_i = 1;
    step();
    chk("mid_r_valid",  64'(r_valid_o),  64'd0);
    chk("mid_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("mid_w_ready",  64'(w_ready_o),  64'd0);
    chk("mid_aw_ready", 64'(aw_ready_o), 64'd1);
    rst_i = 0; r_ready_i = 0;

    // B and R-last complete in the same cycle
    aw_valid_i = 1; aw_id_i = 4'd1;
    step();
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
    step();
    w_valid_i = 0; ar_valid_i = 1; ar_id_i = 4'd2; ar_len_i = 8'd0;
    step();
    ar_valid_i = 0;
    chk("dual_b_valid", 64'(b_valid_o), 64'd1);
    chk("dual_r_last",  64'(r_last_o),  64'd1);
`ifdef PB_DUMMY_TILE_ERR_CNT_EN
    chk("dual_cnt0", 64'(err_cnt_o), 64'd0);
`endif
    b_ready_i = 1; r_ready_i = 1;
    step();
`ifdef PB_DUMMY_TILE_ERR_CNT_EN
    chk("dual_cnt2", 64'(err_cnt_o), 64'd2);
`endif
    chk("dual_idle", 64'(r_valid_o | b_valid_o), 64'd0);
    b_ready_i = 0; r_ready_i = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_i      = ($urandom_range(0, 299) == 0);
      aw_valid_i = 1'($urandom_range(0, 1));
      aw_id_i    = 4'($urandom);
      w_valid_i  = 1'($urandom_range(0, 1));
      w_last_i   = 1'($urandom_range(0, 1));
      b_ready_i  = 1'($urandom_range(0, 1));
      ar_valid_i = 1'($urandom_range(0, 1));
      ar_id_i    = 4'($urandom);
      ar_len_i   = 8'($urandom_range(0, 7));
      r_ready_i  = 1'($urandom_range(0, 1));
      step();
    end
    rst_i = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pb_dummy_tile_err_slv.md
PB_DUMMY_TILE_ERR_SLV -- requirements
Module: pb_dummy_tile_err_slv

Interface
REQ-001 SHALL have parameter IdWidth, default 4, AXI ID width of the tile's NoC chimney port.
REQ-002 SHALL have parameter DataWidth, default 64, read-data width.
REQ-003 SHALL have parameter MaxWrTxns, default 4, depth of the pending-write ID FIFO (power of two, >=2).
REQ-004 SHALL have port clk_i  in  1  sole clock.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports aw_valid_i in 1, aw_ready_o out 1, aw_id_i in IdWidth: write-address handshake and ID.
REQ-007 SHALL have ports w_valid_i in 1, w_ready_o out 1, w_last_i in 1: write-data handshake and last-beat flag (data ignored, not ported).
REQ-008 SHALL have ports b_valid_o out 1, b_ready_i in 1, b_id_o out IdWidth, b_resp_o out 2: write response.
REQ-009 SHALL have ports ar_valid_i in 1, ar_ready_o out 1, ar_id_i in IdWidth, ar_len_i in 8: read-address handshake, ID, beats minus one.
REQ-010 SHALL have ports r_valid_o out 1, r_ready_i in 1, r_id_o out IdWidth, r_data_o out DataWidth, r_resp_o out 2, r_last_o out 1: read data.

Function
REQ-011 SHALL answer every transaction with response DECERR (2'b11) on b_resp_o and r_resp_o.
REQ-012 SHALL push aw_id_i into the write-ID FIFO on aw_valid_i && aw_ready_o; aw_ready_o = FIFO not full.
REQ-013 SHALL drive w_ready_o high only when the write-ID FIFO is non-empty and no B response is pending (b_valid_o low).
REQ-014 SHALL, on a W handshake with w_last_i high, pop the FIFO head into the B register and raise b_valid_o the following cycle (1-cycle latency).
REQ-015 SHALL hold b_valid_o and b_id_o stable until b_ready_i; b_valid_o clears the cycle after the handshake.
REQ-016 SHALL accept a simultaneous AW push and W-last pop in the same cycle, including when the FIFO is full (pop frees no slot that cycle; aw_ready_o stays low).
REQ-017 SHALL implement a read FSM with states R_IDLE and R_BURST; ar_ready_o high only in R_IDLE.
REQ-018 SHALL, on AR handshake in R_IDLE, latch ar_id_i and ar_len_i into a beat counter, enter R_BURST, and assert r_valid_o from the next cycle.
REQ-019 SHALL in R_BURST emit ar_len_i+1 beats; r_data_o = all zeros; r_id_o = latched ID; counter decrements on each R handshake.
REQ-020 SHALL assert r_last_o exactly when the counter is zero; on the r_last_o handshake return to R_IDLE (ar_ready_o high the next cycle).
REQ-021 SHALL hold r_valid_o, r_id_o, r_last_o stable while r_ready_i is low.
REQ-022 SHALL keep read and write paths fully independent; either may stall without affecting the other.

Reset
REQ-023 SHALL, on rst_i high at a clock edge, empty the FIFO, clear the B register, set FSM to R_IDLE and counter to 0, regardless of in-flight bursts.
REQ-024 SHALL drive during and after reset: aw_ready_o 1, w_ready_o 0, b_valid_o 0, b_id_o 0, b_resp_o 2'b11, ar_ready_o 1, r_valid_o 0, r_id_o 0, r_data_o 0, r_resp_o 2'b11, r_last_o 0.

Configuration
REQ-025 SHALL, with macro PB_DUMMY_TILE_ERR_CNT_EN defined, add port err_cnt_o out 32, counting completed B plus completed R bursts (each r_last handshake counts 1), saturating at 2^32-1, reset to 0; two completions in one cycle add 2.
REQ-026 SHALL, without PB_DUMMY_TILE_ERR_CNT_EN, omit err_cnt_o and the counter logic entirely.

Structure
REQ-027 SHALL place the DECERR response constant and the read FSM state enum in picobello_pkg.
REQ-028 SHALL instantiate fifo_v3 from common_cells as the single sub-module for the write-ID FIFO; all other logic is inline.

Verification
REQ-029 SHALL cover: AW id=3, W single beat last=1, b_ready_i=1 -> b_valid_o one cycle after W, b_id_o=3, b_resp_o=2'b11.
REQ-030 SHALL cover: AR id=5 len=7, r_ready_i=1 -> 8 beats, r_last_o only on beat 8, ar_ready_o low until cycle after beat 8.
REQ-031 SHALL cover: 4 AWs (ids 0..3) without W -> aw_ready_o low after 4th; then W-last with concurrent 5th AW -> B id=0, 5th AW accepted one cycle later.
REQ-032 SHALL cover: r_ready_i toggled randomly during len=3 burst -> outputs stable while stalled, exactly 4 beats.
REQ-033 SHALL cover: rst_i asserted mid-burst (beat 2 of len=5) -> next cycle r_valid_o=0, ar_ready_o=1, FIFO empty.
REQ-034 SHALL cover (PB_DUMMY_TILE_ERR_CNT_EN): B and r_last handshakes in the same cycle -> err_cnt_o increments by 2.
